// File: rtl/pos_cell_pkg.sv
`default_nettype none
// ============================================================================
// pos_cell_pkg : shared types and constants for the cell position store
// Rev 1.0
// ============================================================================
package pos_cell_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_e;

  localparam int POS_AXIS_WIDTH = 32;
  localparam int POS_WORD_WIDTH = 3 * POS_AXIS_WIDTH;

  function automatic int addr_width_for(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pos_cell_pingpong_mem_if.sv
`default_nettype none
// ============================================================================
// pos_cell_pingpong_mem_if : read, append and swap signals of the position store
// Rev 1.0
// ============================================================================
interface pos_cell_pingpong_mem_if
  import pos_cell_pkg::*;
#(
  parameter int DATA_WIDTH = POS_WORD_WIDTH,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  app_valid;
  logic [DATA_WIDTH-1:0] app_data;
  logic                  app_ready;
  logic                  app_overflow;
  logic                  swap_req;
  logic                  swap_done;
  logic                  active_bank;

  modport master (
    output rd_en, rd_addr, app_valid, app_data, swap_req,
    input  rd_valid, rd_data, rd_count, app_ready, app_overflow, swap_done, active_bank
  );

  modport slave (
    input  rd_en, rd_addr, app_valid, app_data, swap_req,
    output rd_valid, rd_data, rd_count, app_ready, app_overflow, swap_done, active_bank
  );
endinterface
`default_nettype wire

// File: rtl/pos_cell_bank.sv
`default_nettype none
// ============================================================================
// pos_cell_bank : simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
module pos_cell_bank
  import pos_cell_pkg::*;
#(
  parameter int DATA_WIDTH = POS_WORD_WIDTH,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = addr_width_for(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  we_i,
  input  wire logic [ADDR_WIDTH-1:0] waddr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  input  wire logic                  re_i,
  input  wire logic [ADDR_WIDTH-1:0] raddr_i,
  output logic      [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pos_cell_pingpong_mem.sv
`default_nettype none
// ============================================================================
// pos_cell_pingpong_mem : double-buffered particle position store for one cell
// Rev 1.0
// ============================================================================
module pos_cell_pingpong_mem
  import pos_cell_pkg::*;
#(
  parameter int DATA_WIDTH = POS_WORD_WIDTH,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = addr_width_for(DEPTH),
  parameter int INIT_COUNT = 220
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pos_cell_pingpong_mem_if.slave mem_if
);

  localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_init_cnt  = (ADDR_WIDTH + 1)'(INIT_COUNT);
  localparam logic [ADDR_WIDTH:0] c_one       = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH:0]   count_q [2];
  logic [ADDR_WIDTH:0]   count_d [2];
  logic                  ovf_q, ovf_d;
  logic                  swap_done_q;
  logic                  s1_valid_q, s1_zero_q, s1_bank_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  w_shadow;
  logic                  w_idle;
  logic                  w_rd_accept;
  logic                  w_rd_zero;
  logic                  w_app_ready;
  logic                  w_app_accept;
  logic [ADDR_WIDTH:0]   w_rd_count;
  logic [DATA_WIDTH-1:0] w_bank_rdata [2];

  assign w_shadow     = ~active_q;
  assign w_idle       = (state_q == IDLE);
  assign w_rd_accept  = mem_if.rd_en & w_idle;
  assign w_rd_count   = count_q[active_q];
  assign w_rd_zero    = ({1'b0, mem_if.rd_addr} >= w_rd_count);
  assign w_app_ready  = w_idle && (count_q[w_shadow] < c_depth_cnt);
  assign w_app_accept = mem_if.app_valid & w_app_ready;

  // Each bank is read only while active and written only while shadow.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pos_cell_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .we_i    (w_app_accept && (w_shadow == 1'(b))),
      .waddr_i (count_q[w_shadow][ADDR_WIDTH-1:0]),
      .wdata_i (mem_if.app_data),
      .re_i    (w_rd_accept && (active_q == 1'(b))),
      .raddr_i (mem_if.rd_addr),
      .rdata_o (w_bank_rdata[b])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_if.swap_req) state_d = DRAIN;
      DRAIN:   if (!s1_valid_q && !rd_valid_q) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    ovf_d    = ovf_q;
    if (w_app_accept) begin
      count_d[w_shadow] = count_q[w_shadow] + c_one;
    end
    if (state_q == SWAP) begin
      active_d          = ~active_q;
      count_d[active_q] = '0;
      ovf_d             = 1'b0;
    end
    // A drop in the swap cycle itself belongs to the new shadow bank.
    if (mem_if.app_valid && !w_app_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      count_q[0]  <= c_init_cnt;
      count_q[1]  <= '0;
      ovf_q       <= 1'b0;
      swap_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_bank_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      swap_done_q <= (state_q == SWAP);
      s1_valid_q  <= w_rd_accept;
      if (w_rd_accept) begin
        s1_zero_q <= w_rd_zero;
        s1_bank_q <= active_q;
      end
      rd_valid_q <= s1_valid_q;
      rd_data_q  <= (s1_valid_q && !s1_zero_q) ? w_bank_rdata[s1_bank_q] : '0;
    end
  end

  assign mem_if.rd_valid     = rd_valid_q;
  assign mem_if.rd_data      = rd_data_q;
  assign mem_if.rd_count     = w_rd_count;
  assign mem_if.app_ready    = w_app_ready;
  assign mem_if.app_overflow = ovf_q;
  assign mem_if.swap_done    = swap_done_q;
  assign mem_if.active_bank  = active_q;

endmodule
`default_nettype wire

// File: tb/tb_pos_cell_pingpong_mem.sv
`default_nettype none
// ============================================================================
// tb_pos_cell_pingpong_mem : scoreboard bench for the ping-pong position store
// Rev 1.0
// ============================================================================
module tb_pos_cell_pingpong_mem;
  import pos_cell_pkg::*;

  localparam int DW         = 96;
  localparam int DEPTH      = 256;
  localparam int AW         = 8;
  localparam int INIT_COUNT = 220;

  typedef struct {
    bit          chk;
    logic [DW-1:0] val;
    int          cyc;
    bit          bank;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pos_cell_pingpong_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cell_pingpong_mem #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INIT_COUNT (INIT_COUNT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus)
  );

  sb_t           sb_q[$];
  sb_t           mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  int            m_count [2];
  bit            m_active;
  bit            m_ovf;
  bit            m_idle;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input logic [7:0] tag, input int i);
    return {tag, 24'(i), 32'(i * 7 + 3), 32'hC0DE_0000 | 32'(i)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("rd_valid_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("rd_latency", cyc, mon_e.cyc);
          check_val("rd_bank", bus.active_bank, mon_e.bank);
          if (mon_e.chk) check_val("rd_data", bus.rd_data, mon_e.val);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check_val("rd_valid_missing", 0, 1);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_read(input int a);
    sb_t e;
    e.cyc  = cyc + 2;
    e.bank = m_active;
    if (a >= m_count[m_active]) begin
      e.chk = 1'b1;
      e.val = '0;
    end else begin
      e.chk = m_known[m_active][a];
      e.val = m_mem[m_active][a];
    end
    sb_q.push_back(e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic do_append(input logic [DW-1:0] d);
    int sh;
    bit exp_rdy;
    sh      = m_active ? 0 : 1;
    exp_rdy = m_idle && (m_count[sh] < DEPTH);
    bus.app_valid = 1'b1;
    bus.app_data  = d;
    check_val("app_ready", bus.app_ready, exp_rdy);
    if (exp_rdy) begin
      m_mem[sh][m_count[sh]]   = d;
      m_known[sh][m_count[sh]] = 1'b1;
      m_count[sh]++;
    end else begin
      m_ovf = 1'b1;
    end
    tick();
    bus.app_valid = 1'b0;
  endtask

  task automatic req_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    m_idle = 1'b0;
  endtask

  task automatic wait_swap_done();
    bit seen;
    int old;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.swap_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("swap_done_seen", seen, 1);
    old            = m_active ? 1 : 0;
    m_active       = !m_active;
    m_count[old]   = 0;
    m_ovf          = 1'b0;
    m_idle         = 1'b1;
    check_val("active_bank", bus.active_bank, m_active);
    check_val("rd_count", bus.rd_count, m_count[m_active]);
    check_val("app_overflow_swap", bus.app_overflow, m_ovf);
    @(negedge clk);
    check_val("swap_done_pulse", bus.swap_done, 0);
  endtask

  initial begin
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.app_valid = 1'b0;
    bus.app_data  = '0;
    bus.swap_req  = 1'b0;
    m_active      = 1'b0;
    m_count[0]    = INIT_COUNT;
    m_count[1]    = 0;
    m_idle        = 1'b1;
    m_ovf         = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_rd_valid", bus.rd_valid, 0);
    check_val("rst_rd_data", bus.rd_data, 0);
    check_val("rst_overflow", bus.app_overflow, 0);
    check_val("rst_swap_done", bus.swap_done, 0);
    check_val("rst_active", bus.active_bank, 0);
    check_val("rst_rd_count", bus.rd_count, INIT_COUNT);
    rst = 1'b0;
    tick();

    // Post-reset reads: init words are unknown here, index 220 is forced to zero.
    do_read(0); do_read(1); do_read(219); do_read(220);
    idle(4);

    // Append five words, swap, read them back.
    for (int i = 0; i < 5; i++) do_append(mk_word(8'hA0, i));
    check_val("ovf_after_appends", bus.app_overflow, 0);
    req_swap();
    wait_swap_done();
    for (int a = 0; a <= 5; a++) do_read(a);
    idle(4);

    // Fill the shadow bank to DEPTH, then one more append overflows.
    for (int i = 0; i < DEPTH; i++) do_append(mk_word(8'hF0, i));
    do_append(mk_word(8'hEE, 0));
    check_val("ovf_full", bus.app_overflow, 1);
    req_swap();
    wait_swap_done();
    do_read(0); do_read(128); do_read(255);
    idle(4);

    // Reads in flight drain from the old bank; a read during DRAIN is ignored.
    do_read(10);
    do_read(11);
    bus.swap_req = 1'b1;
    do_read(12);
    bus.swap_req = 1'b0;
    m_idle       = 1'b0;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 8'd13;
    tick();
    bus.rd_en = 1'b0;
    wait_swap_done();
    idle(4);

    // Append lands with swap_req; append in DRAIN is dropped then cleared.
    bus.swap_req = 1'b1;
    do_append(mk_word(8'hD0, 0));
    bus.swap_req = 1'b0;
    m_idle       = 1'b0;
    do_append(mk_word(8'hD0, 1));
    check_val("ovf_drain", bus.app_overflow, 1);
    wait_swap_done();
    do_read(0); do_read(1);
    idle(4);

    // Reset while draining with reads in flight.
    do_append(mk_word(8'hE0, 0));
    req_swap();
    wait_swap_done();
    do_read(0);
    bus.swap_req = 1'b1;
    do_read(0);
    bus.swap_req = 1'b0;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_val("mid_rst_rd_valid", bus.rd_valid, 0);
    check_val("mid_rst_rd_data", bus.rd_data, 0);
    check_val("mid_rst_active", bus.active_bank, 0);
    check_val("mid_rst_rd_count", bus.rd_count, INIT_COUNT);
    repeat (3) begin
      @(negedge clk);
      check_val("mid_rst_swap_done", bus.swap_done, 0);
    end
    rst        = 1'b0;
    m_active   = 1'b0;
    m_count[0] = INIT_COUNT;
    m_count[1] = 0;
    m_ovf      = 1'b0;
    m_idle     = 1'b1;
    check_val("post_rst_active", bus.active_bank, 0);
    check_val("post_rst_rd_count", bus.rd_count, INIT_COUNT);
    check_val("post_rst_overflow", bus.app_overflow, 0);
    check_val("post_rst_app_ready", bus.app_ready, 1);
    tick();
    do_read(0); do_read(200); do_read(220);
    idle(5);

    check_val("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
